eth_tx_clock_rate_ctrl: RTL and testbench
=========================================

Name: eth_tx_clock_rate_ctrl

Overview:
- Generates the 2-bit clock-pattern word stream for the ODDR clock-downsample block, which forwards the Ethernet TX clock (e.g. RGMII TXC).
- Selects the 10/100/1000 Mb/s clock rate, starts and stops the clock, and switches rates glitch-free, changing only at whole-period boundaries.
- Emits a one-cycle tick per output-clock period so the TX datapath knows when to launch data.

Parameters:
- words_1000m_p, 1: period length in 2-bit words at 1000M (clk_i/2).
- words_100m_p, 5: period length in words at 100M (clk_i/10).
- words_10m_p, 50: period length in words at 10M (clk_i/100).
- cnt_width_p, 6: counter width; must hold the largest words_*_p minus 1.

Ports:
- clk_i  in  1  sole clock; same clock as the downsample block.
- reset_i  in  1  synchronous, active-high reset.
- en_i  in  1  clock enable request; level.
- speed_i  in  2  requested rate: 00=10M, 01=100M, 10=1000M, 11=reserved (treated as 10M).
- ready_i  in  1  from downsample ready_o; high means clk_setting_o is consumed at this edge.
- clk_setting_o  out  2  pattern word to downsample clk_setting_i. Bit0 is emitted first, bit1 second.
- tick_o  out  1  one-cycle pulse when the first word of a period is consumed.
- active_o  out  1  high in RUN.
- speed_o  out  2  currently applied rate; reserved requests are reported as 00.

Behaviour:
- Reset: FSM=IDLE, clk_setting_o=00, count=0, speed_o=00, tick_o=0, active_o=0. Reset mid-period aborts immediately; the pattern is not completed.
- Update rule: clk_setting_o, count and speed_o change only on edges with ready_i=1. With ready_i=0, all state holds.
- Pattern: for period N words and word index k, bit0 = (2k < N), bit1 = (2k+1 < N). The registered word equals pattern(speed_o, count).
  - N=1: 01.
  - N=5: 11,11,01,00,00.
  - N=50: 25×11 then 25×00.
- IDLE:
  - clk_setting_o=00.
  - On ready_i & en_i: speed_o←speed_i (11→00), count←0, load word 0, go to RUN.
  - Otherwise remain.
- RUN, on ready_i:
  - If count < N−1: count←count+1, load next word.
  - If count = N−1 (period end) and en_i=1: speed_o←speed_i, count←0, load word 0 of the new rate. This is the only point where the rate changes.
  - If count = N−1 and en_i=0: clk_setting_o←00, count←0, go to IDLE.
- en_i deassert mid-period: the period completes first, so there are no runt pulses. en_i re-asserted before the period end keeps the FSM in RUN without a gap.
- speed_i changes mid-period are ignored until the period end. Only the value at the boundary edge is sampled.
- tick_o = RUN & ready_i & (count==0). It is combinational from state and ready_i. There is no tick on the IDLE→RUN edge; the first tick comes at the next ready_i.
- active_o is high in RUN, including the final period while stopping.

Optional Feature:
- Macro: ETH_TX_CLOCK_RATE_CTRL_READY_CHECK_EN.
- Enabled:
  - Adds output err_o (1 bit), a sticky flag set when ready_i=1 on two consecutive cycles (protocol violation; ready_i must alternate).
  - Cleared only by reset_i. Reset value 0.
  - The offending consumption is still processed normally.
- Disabled: err_o port and check logic are absent; behaviour is otherwise identical.

Test Plan:
- Reset and start at 1000M: ready_i toggling 0/1, en_i=1, speed_i=10. Expect clk_setting_o=01 constant after start, tick_o on every ready_i after the first, active_o=1, speed_o=10.
- 100M pattern: speed_i=01, en_i=1. Expect repeating word sequence 11,11,01,00,00 across consumptions, and tick_o once per 5 ready_i pulses (every 10 clk_i).
- 10M and reserved code: speed_i=11. Expect speed_o=00, 25 words of 11 then 25 words of 00, and tick_o every 100 clk_i.
- Glitch-free switch: in 100M, change speed_i to 10 at count=2. Expect 01,00,00 to complete, then 01 words; speed_o changes on the boundary edge only.
- Stop and restart:
  - Drop en_i at count=1 of 10M. Expect the period to finish, then 00 with active_o=0.
  - Re-assert en_i. Expect restart at word 0.
  - Separately, assert reset_i mid-period. Expect clk_setting_o=00 the next cycle.
- With ETH_TX_CLOCK_RATE_CTRL_READY_CHECK_EN: hold ready_i=1 for 2 cycles. Expect err_o=1, held until reset_i; with alternating ready_i, err_o stays 0.

Source files
------------

// File: rtl/eth_tx_clock_rate_ctrl_if.sv
// Pattern-word and control bundle between the TX clock-rate controller and its user.
// With ETH_TX_CLOCK_RATE_CTRL_READY_CHECK_EN defined the bundle also carries err_o.
interface eth_tx_clock_rate_ctrl_if;
  logic       en_i;
  logic [1:0] speed_i;
  logic       ready_i;
  logic [1:0] clk_setting_o;
  logic       tick_o;
  logic       active_o;
  logic [1:0] speed_o;
`ifdef ETH_TX_CLOCK_RATE_CTRL_READY_CHECK_EN
  logic       err_o;

  modport master (
    input  en_i, speed_i, ready_i,
    output clk_setting_o, tick_o, active_o, speed_o, err_o
  );

  modport slave (
    output en_i, speed_i, ready_i,
    input  clk_setting_o, tick_o, active_o, speed_o, err_o
  );
`else
  modport master (
    input  en_i, speed_i, ready_i,
    output clk_setting_o, tick_o, active_o, speed_o
  );

  modport slave (
    output en_i, speed_i, ready_i,
    input  clk_setting_o, tick_o, active_o, speed_o
  );
`endif
endinterface

// File: rtl/eth_tx_clock_rate_ctrl.sv
// Generates the 2-bit clock-pattern stream for the ODDR downsample block (10/100/1000M, glitch-free).
// Optional ready-alternation check enabled by ETH_TX_CLOCK_RATE_CTRL_READY_CHECK_EN.
module eth_tx_clock_rate_ctrl #(
  parameter int unsigned words_1000m_p = 1,
  parameter int unsigned words_100m_p  = 5,
  parameter int unsigned words_10m_p   = 50,
  parameter int unsigned cnt_width_p   = 6
) (
  input  logic                     clk_i,
  input  logic                     reset_i,
  eth_tx_clock_rate_ctrl_if.master bus
);

  // One extra bit holds the period length itself, one more holds twice the word index.
  localparam int unsigned WordsW = cnt_width_p + 2;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_e;

  state_e                 state_q, state_d;
  logic [cnt_width_p-1:0] count_q, count_d;
  logic [1:0]             speed_q, speed_d;
  logic [1:0]             setting_q, setting_d;
  logic [1:0]             speed_req;

  function automatic logic [WordsW-1:0] period_words(input logic [1:0] spd);
    case (spd)
      2'b10:   period_words = WordsW'(words_1000m_p);
      2'b01:   period_words = WordsW'(words_100m_p);
      default: period_words = WordsW'(words_10m_p);
    endcase
  endfunction

  function automatic logic [cnt_width_p-1:0] last_idx(input logic [1:0] spd);
    last_idx = cnt_width_p'(period_words(spd) - WordsW'(1));
  endfunction

  // Half-cycle j of the period is high while j < N; word k carries half-cycles 2k and 2k+1.
  function automatic logic [1:0] pattern(input logic [1:0] spd, input logic [cnt_width_p-1:0] idx);
    logic [WordsW-1:0] n;
    logic [WordsW-1:0] half0;
    logic [WordsW-1:0] half1;
    n       = period_words(spd);
    half0   = {1'b0, idx, 1'b0};
    half1   = {1'b0, idx, 1'b1};
    pattern = {(half1 < n), (half0 < n)};
  endfunction

  assign speed_req = (bus.speed_i == 2'b11) ? 2'b00 : bus.speed_i;

  // Next-state: everything advances only on a consumed word.
  always_comb begin
    state_d   = state_q;
    count_d   = count_q;
    speed_d   = speed_q;
    setting_d = setting_q;
    case (state_q)
      IDLE: begin
        if (bus.ready_i && bus.en_i) begin
          state_d   = RUN;
          speed_d   = speed_req;
          count_d   = '0;
          setting_d = pattern(speed_req, '0);
        end
      end
      RUN: begin
        if (bus.ready_i) begin
          if (count_q < last_idx(speed_q)) begin
            count_d   = count_q + cnt_width_p'(1);
            setting_d = pattern(speed_q, count_q + cnt_width_p'(1));
          end else if (bus.en_i) begin
            // Period boundary: the only place a new rate is taken.
            speed_d   = speed_req;
            count_d   = '0;
            setting_d = pattern(speed_req, '0);
          end else begin
            state_d   = IDLE;
            count_d   = '0;
            setting_d = 2'b00;
          end
        end
      end
      default: begin
        state_d   = IDLE;
        count_d   = '0;
        setting_d = 2'b00;
      end
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q   <= IDLE;
      count_q   <= '0;
      speed_q   <= 2'b00;
      setting_q <= 2'b00;
    end else begin
      state_q   <= state_d;
      count_q   <= count_d;
      speed_q   <= speed_d;
      setting_q <= setting_d;
    end
  end

  assign bus.clk_setting_o = setting_q;
  assign bus.speed_o       = speed_q;
  assign bus.active_o      = (state_q == RUN);
  assign bus.tick_o        = (state_q == RUN) & bus.ready_i & (count_q == '0);

`ifdef ETH_TX_CLOCK_RATE_CTRL_READY_CHECK_EN
  logic ready_q;
  logic err_q;

  // Sticky flag for back-to-back consumptions; the word is still processed.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      ready_q <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      ready_q <= bus.ready_i;
      err_q   <= err_q | (ready_q & bus.ready_i);
    end
  end

  assign bus.err_o = err_q;
`endif

endmodule

// File: tb/tb_eth_tx_clock_rate_ctrl.sv
// Randomized self-checking bench for eth_tx_clock_rate_ctrl against a period-queue reference model.
// Define ETH_TX_CLOCK_RATE_CTRL_READY_CHECK_EN to also exercise err_o.
module tb_eth_tx_clock_rate_ctrl;

  logic clk_i = 1'b0;
  logic reset_i;
  always #5 clk_i = ~clk_i;

  eth_tx_clock_rate_ctrl_if bus ();

  eth_tx_clock_rate_ctrl #(
    .words_1000m_p(1),
    .words_100m_p (5),
    .words_10m_p  (50),
    .cnt_width_p  (6)
  ) dut (
    .clk_i  (clk_i),
    .reset_i(reset_i),
    .bus    (bus)
  );

  int n_total = 0;
  int n_pass  = 0;

  // Reference model: the current word plus a queue of the words still owed in this period.
  logic       m_run, m_first, m_err, m_prev_rdy;
  logic [1:0] m_word, m_spd;
  logic [1:0] m_rest[$];
  logic       obs_tick, exp_tick, last_rdy;

  function automatic int n_of(input logic [1:0] s);
    if (s == 2'b10) return 1;
    if (s == 2'b01) return 5;
    return 50;
  endfunction

  function automatic void model_reset();
    m_run = 1'b0; m_first = 1'b0; m_err = 1'b0; m_prev_rdy = 1'b0;
    m_word = 2'b00; m_spd = 2'b00;
    m_rest.delete();
  endfunction

  function automatic void load_period(input logic [1:0] spd);
    int n;
    m_spd = (spd == 2'b11) ? 2'b00 : spd;
    n = n_of(m_spd);
    m_rest.delete();
    for (int k = 0; k < n; k++) m_rest.push_back({(2*k+1 < n), (2*k < n)});
    m_word  = m_rest.pop_front();
    m_first = 1'b1;
  endfunction

  function automatic void model_step(input logic en, input logic [1:0] spd,
                                     input logic rdy, input logic rst);
    if (rst) begin
      model_reset();
      return;
    end
    if (m_prev_rdy && rdy) m_err = 1'b1;
    m_prev_rdy = rdy;
    if (!rdy) return;
    if (!m_run) begin
      if (en) begin
        load_period(spd);
        m_run = 1'b1;
      end
    end else if (m_rest.size() > 0) begin
      m_word  = m_rest.pop_front();
      m_first = 1'b0;
    end else if (en) begin
      load_period(spd);
    end else begin
      m_word = 2'b00;
      m_run  = 1'b0;
    end
  endfunction

  // One clock: drive at negedge, sample the combinational tick before the edge, registers after.
  task automatic cycle(input logic en, input logic [1:0] spd, input logic rdy, input logic rst);
    @(negedge clk_i);
    bus.en_i    = en;
    bus.speed_i = spd;
    bus.ready_i = rdy;
    reset_i     = rst;
    #1;
    obs_tick = bus.tick_o;
    exp_tick = m_run & rdy & m_first;
    @(posedge clk_i);
    model_step(en, spd, rdy, rst);
    last_rdy = rdy;
    #1;
  endtask

  function automatic logic [6:0] exp_vec();
    logic e;
`ifdef ETH_TX_CLOCK_RATE_CTRL_READY_CHECK_EN
    e = m_err;
`else
    e = 1'b0;
`endif
    return {exp_tick, m_word, m_spd, m_run, e};
  endfunction

  function automatic logic [6:0] obs_vec();
    logic e;
`ifdef ETH_TX_CLOCK_RATE_CTRL_READY_CHECK_EN
    e = bus.err_o;
`else
    e = 1'b0;
`endif
    return {obs_tick, bus.clk_setting_o, bus.speed_o, bus.active_o, e};
  endfunction

  task automatic do_reset();
    cycle(1'b0, 2'b00, 1'b0, 1'b1);
    cycle(1'b0, 2'b00, 1'b0, 1'b0);
  endtask

  task automatic test_reset();
    cycle(1'b1, 2'b01, 1'b0, 1'b1);
    cycle(1'b1, 2'b01, 1'b0, 1'b1);
    cycle(1'b0, 2'b00, 1'b0, 1'b1);
    n_total++;
    if (obs_vec() !== exp_vec()) $display("FAIL reset_vec: got %b want %b", obs_vec(), exp_vec());
    else n_pass++;
    n_total++;
    if (bus.clk_setting_o !== 2'b00 || bus.speed_o !== 2'b00 || bus.active_o !== 1'b0 || obs_tick !== 1'b0)
      $display("FAIL reset_const: got set=%b spd=%b act=%b tick=%b want 00 00 0 0",
               bus.clk_setting_o, bus.speed_o, bus.active_o, obs_tick);
    else n_pass++;
    cycle(1'b0, 2'b00, 1'b0, 1'b0);
  endtask

  task automatic test_1000m();
    int ticks = 0, cons = 0;
    logic r;
    do_reset();
    for (int i = 0; i < 40; i++) begin
      r = !last_rdy;
      cycle(1'b1, 2'b10, r, 1'b0);
      if (r) cons++;
      if (obs_tick) ticks++;
      n_total++;
      if (obs_vec() !== exp_vec()) $display("FAIL 1000m_vec cyc %0d: got %b want %b", i, obs_vec(), exp_vec());
      else n_pass++;
      if (cons > 0) begin
        n_total++;
        if (bus.clk_setting_o !== 2'b01 || bus.speed_o !== 2'b10)
          $display("FAIL 1000m_word cyc %0d: got %b/%b want 01/10", i, bus.clk_setting_o, bus.speed_o);
        else n_pass++;
      end
    end
    n_total++;
    if (ticks !== cons - 1) $display("FAIL 1000m_ticks: got %0d want %0d", ticks, cons - 1);
    else n_pass++;
  endtask

  task automatic test_100m();
    logic [1:0] exp100[5] = '{2'b11, 2'b11, 2'b01, 2'b00, 2'b00};
    int cons = 0, prev_tick = -1;
    logic r;
    do_reset();
    for (int i = 0; i < 60; i++) begin
      r = !last_rdy;
      cycle(1'b1, 2'b01, r, 1'b0);
      n_total++;
      if (obs_vec() !== exp_vec()) $display("FAIL 100m_vec cyc %0d: got %b want %b", i, obs_vec(), exp_vec());
      else n_pass++;
      if (obs_tick) begin
        if (prev_tick >= 0) begin
          n_total++;
          if (i - prev_tick !== 10) $display("FAIL 100m_tick_gap: got %0d want 10", i - prev_tick);
          else n_pass++;
        end
        prev_tick = i;
      end
      if (r) begin
        n_total++;
        if (bus.clk_setting_o !== exp100[cons % 5])
          $display("FAIL 100m_word %0d: got %b want %b", cons, bus.clk_setting_o, exp100[cons % 5]);
        else n_pass++;
        cons++;
      end
    end
  endtask

  task automatic test_10m_reserved();
    int cons = 0, prev_tick = -1;
    logic r;
    logic [1:0] w;
    do_reset();
    for (int i = 0; i < 260; i++) begin
      r = !last_rdy;
      cycle(1'b1, 2'b11, r, 1'b0);
      n_total++;
      if (obs_vec() !== exp_vec()) $display("FAIL 10m_vec cyc %0d: got %b want %b", i, obs_vec(), exp_vec());
      else n_pass++;
      if (obs_tick) begin
        if (prev_tick >= 0) begin
          n_total++;
          if (i - prev_tick !== 100) $display("FAIL 10m_tick_gap: got %0d want 100", i - prev_tick);
          else n_pass++;
        end
        prev_tick = i;
      end
      if (r) begin
        w = ((cons % 50) < 25) ? 2'b11 : 2'b00;
        n_total++;
        if (bus.clk_setting_o !== w || bus.speed_o !== 2'b00)
          $display("FAIL 10m_word %0d: got %b/%b want %b/00", cons, bus.clk_setting_o, bus.speed_o, w);
        else n_pass++;
        cons++;
      end
    end
  endtask

  task automatic test_switch();
    logic [1:0] exp_w[5] = '{2'b01, 2'b00, 2'b00, 2'b01, 2'b01};
    logic [1:0] exp_s[5] = '{2'b01, 2'b01, 2'b01, 2'b10, 2'b10};
    logic [1:0] rec_w[5];
    logic [1:0] rec_s[5];
    bit   hit = 0;
    int   nrec;
    logic r;
    do_reset();
    for (int i = 0; i < 40 && !hit; i++) begin
      r = !last_rdy;
      cycle(1'b1, 2'b01, r, 1'b0);
      n_total++;
      if (obs_vec() !== exp_vec()) $display("FAIL switch_vec cyc %0d: got %b want %b", i, obs_vec(), exp_vec());
      else n_pass++;
      if (m_run && m_spd == 2'b01 && m_rest.size() == 2) hit = 1;
    end
    n_total++;
    if (!hit) $display("FAIL switch_timeout: got no count=2 want count=2 within 40 cycles");
    else n_pass++;
    rec_w[0] = bus.clk_setting_o;
    rec_s[0] = bus.speed_o;
    nrec = 1;
    for (int i = 0; i < 12; i++) begin
      r = !last_rdy;
      cycle(1'b1, 2'b10, r, 1'b0);
      n_total++;
      if (obs_vec() !== exp_vec()) $display("FAIL switch_vec2 cyc %0d: got %b want %b", i, obs_vec(), exp_vec());
      else n_pass++;
      if (r && nrec < 5) begin
        rec_w[nrec] = bus.clk_setting_o;
        rec_s[nrec] = bus.speed_o;
        nrec++;
      end
    end
    for (int k = 0; k < 5; k++) begin
      n_total++;
      if (rec_w[k] !== exp_w[k] || rec_s[k] !== exp_s[k])
        $display("FAIL switch_seq %0d: got %b/%b want %b/%b", k, rec_w[k], rec_s[k], exp_w[k], exp_s[k]);
      else n_pass++;
    end
  endtask

  task automatic test_stop_restart();
    bit   hit = 0;
    bit   first = 1;
    logic r;
    do_reset();
    for (int i = 0; i < 20 && !hit; i++) begin
      r = !last_rdy;
      cycle(1'b1, 2'b00, r, 1'b0);
      n_total++;
      if (obs_vec() !== exp_vec()) $display("FAIL stop_vec cyc %0d: got %b want %b", i, obs_vec(), exp_vec());
      else n_pass++;
      if (m_run && m_rest.size() == 48) hit = 1;
    end
    n_total++;
    if (!hit) $display("FAIL stop_timeout: got no count=1 want count=1 within 20 cycles");
    else n_pass++;
    for (int i = 0; i < 120; i++) begin
      r = !last_rdy;
      cycle(1'b0, 2'b00, r, 1'b0);
      n_total++;
      if (obs_vec() !== exp_vec()) $display("FAIL stop_drain cyc %0d: got %b want %b", i, obs_vec(), exp_vec());
      else n_pass++;
    end
    n_total++;
    if (bus.active_o !== 1'b0 || bus.clk_setting_o !== 2'b00)
      $display("FAIL stop_idle: got act=%b set=%b want 0 00", bus.active_o, bus.clk_setting_o);
    else n_pass++;
    for (int i = 0; i < 10; i++) begin
      r = !last_rdy;
      cycle(1'b1, 2'b00, r, 1'b0);
      n_total++;
      if (obs_vec() !== exp_vec()) $display("FAIL restart_vec cyc %0d: got %b want %b", i, obs_vec(), exp_vec());
      else n_pass++;
      if (r && first) begin
        first = 0;
        n_total++;
        if (bus.active_o !== 1'b1 || bus.clk_setting_o !== 2'b11 || obs_tick !== 1'b0)
          $display("FAIL restart_word0: got act=%b set=%b tick=%b want 1 11 0",
                   bus.active_o, bus.clk_setting_o, obs_tick);
        else n_pass++;
      end
    end
  endtask

  task automatic test_reset_mid();
    cycle(1'b1, 2'b00, 1'b0, 1'b1);
    n_total++;
    if (obs_vec() !== exp_vec()) $display("FAIL reset_mid_vec: got %b want %b", obs_vec(), exp_vec());
    else n_pass++;
    n_total++;
    if (bus.clk_setting_o !== 2'b00 || bus.active_o !== 1'b0)
      $display("FAIL reset_mid_const: got set=%b act=%b want 00 0", bus.clk_setting_o, bus.active_o);
    else n_pass++;
    cycle(1'b0, 2'b00, 1'b0, 1'b0);
  endtask

  task automatic test_random();
    logic       en, r, rst;
    logic [1:0] spd = 2'b01;
    do_reset();
    for (int i = 0; i < 1500; i++) begin
      en  = ($urandom_range(0, 7) != 0);
      if ($urandom_range(0, 15) == 0) spd = 2'($urandom);
      r   = last_rdy ? 1'b0 : ($urandom_range(0, 3) != 0);
      rst = ($urandom_range(0, 399) == 0);
      cycle(en, spd, r, rst);
      n_total++;
      if (obs_vec() !== exp_vec()) $display("FAIL random_vec cyc %0d: got %b want %b", i, obs_vec(), exp_vec());
      else n_pass++;
    end
  endtask

`ifdef ETH_TX_CLOCK_RATE_CTRL_READY_CHECK_EN
  task automatic test_ready_check();
    do_reset();
    for (int i = 0; i < 20; i++) begin
      cycle(1'b1, 2'b01, !last_rdy, 1'b0);
      n_total++;
      if (bus.err_o !== 1'b0 || obs_vec() !== exp_vec())
        $display("FAIL err_quiet cyc %0d: got err=%b vec=%b want err=0 vec=%b", i, bus.err_o, obs_vec(), exp_vec());
      else n_pass++;
    end
    cycle(1'b1, 2'b01, 1'b1, 1'b0);
    cycle(1'b1, 2'b01, 1'b1, 1'b0);
    n_total++;
    if (bus.err_o !== 1'b1 || obs_vec() !== exp_vec())
      $display("FAIL err_set: got err=%b vec=%b want err=1 vec=%b", bus.err_o, obs_vec(), exp_vec());
    else n_pass++;
    for (int i = 0; i < 10; i++) begin
      cycle(1'b1, 2'b01, !last_rdy, 1'b0);
      n_total++;
      if (bus.err_o !== 1'b1) $display("FAIL err_sticky cyc %0d: got %b want 1", i, bus.err_o);
      else n_pass++;
    end
    do_reset();
    n_total++;
    if (bus.err_o !== 1'b0) $display("FAIL err_clear: got %b want 0", bus.err_o);
    else n_pass++;
  endtask
`endif

  initial begin
    bus.en_i    = 1'b0;
    bus.speed_i = 2'b00;
    bus.ready_i = 1'b0;
    reset_i     = 1'b1;
    last_rdy    = 1'b0;
    obs_tick    = 1'b0;
    exp_tick    = 1'b0;
    model_reset();
    test_reset();
    test_1000m();
    test_100m();
    test_10m_reserved();
    test_switch();
    test_stop_restart();
    test_reset_mid();
    test_random();
`ifdef ETH_TX_CLOCK_RATE_CTRL_READY_CHECK_EN
    test_ready_check();
`endif
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
